// File: rtl/board_ctl_if.sv
// Mouse/start inputs and registered board state of the tic-tac-toe controller.
// The controller takes the slave side; the video/mouse glue takes the master side.
interface board_ctl_if;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        start_btn;
    logic        start_en;
    logic [8:0]  square;
    logic [8:0]  owner;
    logic        player;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left, start_btn,
        input  start_en, square, owner, player, game_over, winner
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left, start_btn,
        output start_en, square, owner, player, game_over, winner
    );
endinterface

// File: rtl/board_ctl.sv
// Tic-tac-toe game controller: maps mouse clicks to cells, tracks turns and
// detects win/draw. All outputs come straight from registers.
module board_ctl (
    input  logic        pclk,
    input  logic        rst,
    board_ctl_if.slave  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_WIN,
        S_DRAW
    } state_t;

    state_t     r_state;
    logic       r_left_q;
    logic       r_start_q;
    logic [8:0] r_square;
    logic [8:0] r_owner;
    logic       r_player;
    logic       r_start_en;
    logic       r_game_over;
    logic [1:0] r_winner;

    logic       w_click;
    logic       w_start;
    logic       w_restart;
    logic [1:0] w_col;
    logic [1:0] w_row;
    logic [3:0] w_idx;
    logic [8:0] w_cell;
    logic       w_onboard;
    logic       w_free;
    logic [8:0] w_pos;
    logic       w_win;
    logic       w_full;

    assign w_click = io_bus.mouse_left & ~r_left_q;
    assign w_start = io_bus.start_btn & ~r_start_q;
    // CHECK is a single evaluation cycle; a restart there would race the verdict
    assign w_restart = w_start && (r_state != S_CHECK);

    always_comb begin
        w_col = 2'd0;
        w_row = 2'd0;
        if (io_bus.mouse_xpos <= 12'd338)
            w_col = 2'd0;
        else if (io_bus.mouse_xpos <= 12'd679)
            w_col = 2'd1;
        else
            w_col = 2'd2;
        if (io_bus.mouse_ypos <= 12'd251)
            w_row = 2'd0;
        else if (io_bus.mouse_ypos <= 12'd507)
            w_row = 2'd1;
        else
            w_row = 2'd2;
    end

    assign w_onboard = (io_bus.mouse_xpos <= 12'd1023)
                    && (io_bus.mouse_ypos <= 12'd767);
    assign w_idx  = ({2'b00, w_row} * 4'd3) + {2'b00, w_col};
    assign w_cell = 9'd1 << w_idx;
    assign w_free = w_onboard && ((r_square & w_cell) == 9'd0);

    // Cells held by the side that just moved
    assign w_pos = r_square & (r_player ? r_owner : ~r_owner);
    assign w_win = (&w_pos[2:0]) | (&w_pos[5:3]) | (&w_pos[8:6])
                 | (w_pos[0] & w_pos[3] & w_pos[6])
                 | (w_pos[1] & w_pos[4] & w_pos[7])
                 | (w_pos[2] & w_pos[5] & w_pos[8])
                 | (w_pos[0] & w_pos[4] & w_pos[8])
                 | (w_pos[2] & w_pos[4] & w_pos[6]);
    assign w_full = &r_square;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_left_q    <= 1'b0;
            r_start_q   <= 1'b0;
            r_square    <= 9'd0;
            r_owner     <= 9'd0;
            r_player    <= 1'b0;
            r_start_en  <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            r_left_q  <= io_bus.mouse_left;
            r_start_q <= io_bus.start_btn;
            if (w_restart) begin
                r_state     <= S_PLAY;
                r_square    <= 9'd0;
                r_owner     <= 9'd0;
                r_player    <= 1'b0;
                r_start_en  <= 1'b1;
                r_game_over <= 1'b0;
                r_winner    <= 2'b00;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_PLAY: begin
                        if (w_click && w_free) begin
                            r_square <= r_square | w_cell;
                            if (r_player)
                                r_owner <= r_owner | w_cell;
                            else
                                r_owner <= r_owner & ~w_cell;
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (w_win) begin
                            r_winner    <= r_player ? 2'b10 : 2'b01;
                            r_game_over <= 1'b1;
                            r_state     <= S_WIN;
                        end else if (w_full) begin
                            r_winner    <= 2'b11;
                            r_game_over <= 1'b1;
                            r_state     <= S_DRAW;
                        end else begin
                            r_player <= ~r_player;
                            r_state  <= S_PLAY;
                        end
                    end
                    S_WIN, S_DRAW: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_bus.start_en  = r_start_en;
    assign io_bus.square    = r_square;
    assign io_bus.owner     = r_owner;
    assign io_bus.player    = r_player;
    assign io_bus.game_over = r_game_over;
    assign io_bus.winner    = r_winner;
endmodule

// File: doc/board_ctl.md
BOARD_CTL -- requirements
Module: board_ctl

Interface
REQ-001 pclk  input  1  pixel clock; the only clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 mouse_xpos  input  12  cursor X in screen pixels (0..1023 valid).
REQ-004 mouse_ypos  input  12  cursor Y in screen pixels (0..767 valid).
REQ-005 mouse_left  input  1  left button level, synchronous to pclk.
REQ-006 start_btn  input  1  start/restart request level, synchronous to pclk.
REQ-007 start_en  output  1  game active/board displayed; feeds the square drawing stages.
REQ-008 square  output  9  square[i]=1 when cell i is occupied; i = 3*row + col; square[0] drives the square1 input of the first drawing stage.
REQ-009 owner  output  9  owner[i]=1: cell i holds player O; 0: player X; meaningful only when square[i]=1.
REQ-010 player  output  1  side to move: 0 = X, 1 = O.
REQ-011 game_over  output  1  the game has ended in a win or a draw.
REQ-012 winner  output  2  2'b00 none, 2'b01 X, 2'b10 O, 2'b11 draw.

Function
REQ-013 The block SHALL register mouse_left and start_btn once and SHALL define click = mouse_left & ~mouse_left_q and start = start_btn & ~start_btn_q (rising edges only).
REQ-014 Column mapping SHALL be: x<=338 -> 0; 339..679 -> 1; 680..1023 -> 2. Row mapping SHALL be: y<=251 -> 0; 252..507 -> 1; 508..767 -> 2.
REQ-015 A position with x>1023 or y>767 SHALL be off-board, and a click there SHALL be ignored.
REQ-016 The FSM SHALL have the states IDLE, PLAY, CHECK, WIN and DRAW.
REQ-017 In IDLE, start SHALL clear square and owner, set player=0 and move to PLAY on the next edge.
REQ-018 In PLAY, a click on a free on-board cell i SHALL, on the next edge, set square[i]=1 and owner[i]=player, and move to CHECK.
REQ-019 In PLAY, a click on an occupied or off-board cell SHALL leave all state unchanged.
REQ-020 In CHECK, the block SHALL evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) for the mover (owner==player on all three occupied cells).
REQ-021 On a win, CHECK SHALL set winner = player ? 2'b10 : 2'b01 and move to WIN.
REQ-022 With no win and all 9 cells occupied, CHECK SHALL set winner=2'b11 and move to DRAW.
REQ-023 Otherwise, CHECK SHALL toggle player and return to PLAY.
REQ-024 CHECK SHALL last exactly one cycle, and clicks during CHECK SHALL be ignored.
REQ-025 When both a win and a full board occur, the win SHALL take priority over the draw.
REQ-026 In WIN and DRAW, the board SHALL stay frozen, and game_over SHALL be 1.
REQ-027 In WIN and DRAW, start SHALL clear the board, set player=0 and winner=0, and move to PLAY.
REQ-028 In PLAY, start SHALL restart identically, taking priority over a simultaneous click.
REQ-029 start_en SHALL be 1 in every state except IDLE.
REQ-030 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-031 Latency SHALL be: the cell appears on square/owner 1 cycle after the click edge; winner, game_over and player are valid 2 cycles after it.

Reset
REQ-032 While rst=1, the block SHALL asynchronously force state=IDLE, start_en=0, square=0, owner=0, player=0, game_over=0, winner=0, and clear both edge-detect registers.
REQ-033 A reset asserted mid-game SHALL abandon the game with no partial update.
REQ-034 After release, a start edge SHALL be required before play.

Verification
REQ-035 Reset, then pulse start_btn -> start_en=1, square=0, player=0.
REQ-036 Click at (100,100) -> square=9'b000000001, owner[0]=0, player=1 two cycles after the click.
REQ-037 Click the same cell again -> no change.
REQ-038 Click at (1100,100) -> no change.
REQ-039 Hold mouse_left high for 10 cycles -> exactly one move is registered.
REQ-040 X plays cells 0,1,2 while O plays 3,4 -> after the cell-2 click, winner=2'b01 and game_over=1; further clicks are ignored.
REQ-041 Play the sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 -> winner=2'b11 and square=9'h1FF.
REQ-042 Assert rst mid-game -> all outputs read 0 immediately, before the next pclk edge.
REQ-043 Pulse start_btn in WIN -> board cleared, player=0, state=PLAY.
